osc_sequencer: RTL and testbench
================================

// Module: osc_sequencer
// PURPOSE
//  Control stage directly upstream of the recursive sine oscillator. Holds the
//  host-written coefficient set (init1 = sin seed, init2 = 2cos(w), Q3.29), emits
//  the one-cycle Ready load pulse and the periodic Enable sample strobe, and
//  re-seeds the oscillator after a programmable sample count to cancel drift.
// PARAMETERS
//  DATA_W    32  width of init1/init2 coefficient words
//  DIV_W     16  width of sample-rate divider (cfg_div)
//  RELOAD_W  24  width of reload count (cfg_reload) and sample_cnt
// PORTS
//  Fg_CLK      in   1         system clock, all logic rising-edge
//  RESETn      in   1         async active-low reset
//  cfg_valid   in   1         host config word valid
//  cfg_ready   out  1         config shadow free, may accept
//  cfg_init    in   DATA_W    sin seed to present on init1
//  cfg_coef    in   DATA_W    2cos(w) coefficient to present on init2
//  cfg_div     in   DIV_W     Fg_CLK cycles per sample (0 treated as 1)
//  cfg_reload  in   RELOAD_W  samples between re-seeds (0 = never)
//  start       in   1         begin generation (1-cycle pulse or level)
//  stop        in   1         halt generation
//  init1       out  DATA_W    active sin seed to oscillator
//  init2       out  DATA_W    active coefficient to oscillator
//  Ready       out  1         1-cycle load strobe to oscillator
//  Enable      out  1         1-cycle sample strobe to oscillator
//  running     out  1         high in LOAD or RUN
//  sample_cnt  out  RELOAD_W  Enable pulses since last LOAD
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cfg_ready=1; shadow, active, pending,
//   have_cfg, div counter cleared. Reset mid-operation aborts immediately.
//  Config: cfg_valid&cfg_ready captures init/coef/div/reload into shadow, sets
//   pending=1 and have_cfg=1; cfg_ready = ~pending (registered, low next cycle).
//   pending clears only on entry to LOAD (shadow -> active copy).
//  All outputs registered. States IDLE, LOAD, RUN:
//  IDLE: Ready=Enable=0. start & have_cfg & ~stop -> LOAD. start w/o cfg ignored.
//  LOAD: exactly 1 cycle; Ready=1, Enable=0; init1/init2 already hold new active
//   values this cycle; sample_cnt=0, div counter=0. Next: RUN (stop -> IDLE).
//  RUN: div counter counts 0..D-1 (D = max(active div,1)); Enable=1 on the cycle
//   count==D-1, then count wraps to 0, sample_cnt +1 (saturates at all-ones).
//   First Enable is D cycles after the Ready cycle; thereafter every D cycles.
//  Re-seed: on the Enable cycle where sample_cnt+1 == active reload (reload!=0),
//   or where pending=1, next state is LOAD (pending shadow applied if present).
//   That sample period is therefore D+1 cycles (LOAD inserts one cycle).
//  stop: highest priority; from LOAD/RUN -> IDLE next cycle, no Ready/Enable
//   afterwards; stop coincident with an Enable still outputs that Enable.
//   pending shadow retained across stop. start while in LOAD/RUN ignored.
//  init1/init2 change only on LOAD entry; stable at all other times.
// TESTING
//  1 Reset: RESETn=0 -> all outputs 0, cfg_ready=1; start pulse w/o cfg -> stays IDLE.
//  2 cfg init=0x0C3EF153 coef=0x3B20D79E div=4 reload=0, start -> Ready 1 cycle
//    with init1/init2 = those values; Enable at Ready+4,+8,+12; sample_cnt 1,2,3.
//  3 div=0 and div=1 -> Enable every cycle after Ready cycle, never two Readys.
//  4 div=2 reload=3 -> Enable x3, then Ready (gap 3 cycles), sample_cnt 0, repeats.
//  5 New cfg (div=5) during RUN div=4 -> cfg_ready low, 2nd cfg_valid not taken;
//    after next Enable Ready pulses with new init, then Enable every 5, cfg_ready=1.
//  6 stop on an Enable cycle with pending cfg -> that Enable seen, IDLE next, no
//    Ready; later start -> LOAD applies pending; RESETn low mid-RUN -> all 0 at once.

Source files
------------

// File: rtl/osc_sequencer.sv
// osc_sequencer: coefficient shadow/active registers, load and sample strobes, periodic re-seed for the sine oscillator
module osc_sequencer #(
  parameter int DATA_W   = 32,
  parameter int DIV_W    = 16,
  parameter int RELOAD_W = 24
) (
  input  logic                Fg_CLK,
  input  logic                RESETn,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DATA_W-1:0]   cfg_init,
  input  logic [DATA_W-1:0]   cfg_coef,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [RELOAD_W-1:0] cfg_reload,
  input  logic                start,
  input  logic                stop,
  output logic [DATA_W-1:0]   init1,
  output logic [DATA_W-1:0]   init2,
  output logic                Ready,
  output logic                Enable,
  output logic                running,
  output logic [RELOAD_W-1:0] sample_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, nstate;
  logic [DATA_W-1:0] sh_init, sh_coef;
  logic [DIV_W-1:0] sh_div, act_div, cnt, ncnt, dm1;
  logic [RELOAD_W-1:0] sh_reload, act_reload;
  logic pending, have_cfg, accept, npend, load, samp, reseed;
  always_comb begin
    dm1    = (act_div == '0) ? '0 : act_div - DIV_W'(1);
    samp   = (state == RUN) & Enable;
    reseed = samp & (pending | (act_reload != '0 && sample_cnt + RELOAD_W'(1) == act_reload));
    // stop outranks everything once generation is under way
    nstate = (state == IDLE) ? ((start & have_cfg & ~stop) ? LOAD : IDLE) :
             stop ? IDLE : (state == LOAD) ? RUN : reseed ? LOAD : RUN;
    ncnt   = (state == RUN && cnt != dm1) ? cnt + DIV_W'(1) : '0;
    load   = nstate == LOAD;
    accept = cfg_valid & cfg_ready;
    npend  = accept | (pending & ~load);
  end
  always_ff @(posedge Fg_CLK or negedge RESETn)
    if (!RESETn) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt        <= '0;
      Ready      <= 1'b0;
      Enable     <= 1'b0;
      running    <= 1'b0;
      pending    <= 1'b0;
      have_cfg   <= 1'b0;
      cfg_ready  <= 1'b1;
      sh_init    <= '0;
      sh_coef    <= '0;
      sh_div     <= '0;
      sh_reload  <= '0;
      init1      <= '0;
      init2      <= '0;
      act_div    <= '0;
      act_reload <= '0;
      sample_cnt <= '0;
    end else begin
      cnt       <= ncnt;
      Ready     <= load;
      Enable    <= (nstate == RUN) && (ncnt == dm1);
      running   <= nstate != IDLE;
      pending   <= npend;
      cfg_ready <= ~npend;
      have_cfg  <= have_cfg | accept;
      if (accept) begin
        sh_init   <= cfg_init;
        sh_coef   <= cfg_coef;
        sh_div    <= cfg_div;
        sh_reload <= cfg_reload;
      end
      if (load) begin
        init1      <= sh_init;
        init2      <= sh_coef;
        act_div    <= sh_div;
        act_reload <= sh_reload;
      end
      sample_cnt <= load ? '0 : (samp && !(&sample_cnt)) ? sample_cnt + RELOAD_W'(1) : sample_cnt;
    end
  end
endmodule

// File: tb/tb_osc_sequencer.sv
// tb_osc_sequencer: table-driven config vectors plus corner sequences, strobes checked against a scoreboard of expected events
module tb_osc_sequencer;
  logic Fg_CLK = 1'b0, RESETn = 1'b0;
  logic cfg_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] cfg_init = '0, cfg_coef = '0;
  logic [15:0] cfg_div = '0;
  logic [23:0] cfg_reload = '0;
  logic cfg_ready, Ready, Enable, running;
  logic [31:0] init1, init2;
  logic [23:0] sample_cnt;
  int cyc = 0, ntests = 0, nfail = 0;

  osc_sequencer dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_init(cfg_init), .cfg_coef(cfg_coef), .cfg_div(cfg_div), .cfg_reload(cfg_reload),
    .start(start), .stop(stop), .init1(init1), .init2(init2), .Ready(Ready),
    .Enable(Enable), .running(running), .sample_cnt(sample_cnt)
  );

  always #5 Fg_CLK = ~Fg_CLK;
  always @(posedge Fg_CLK) cyc <= cyc + 1;

  typedef struct {
    logic        rdy;
    int          cyc;
    logic [31:0] i1, i2;
    logic [23:0] scnt;
  } ev_t;
  ev_t sbq[$];

  typedef struct {
    logic [31:0] init, coef;
    logic [15:0] div;
    logic [23:0] reload;
    int          nsamp;
    int          period;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Fg_CLK) begin
    ev_t e;
    if (RESETn === 1'b1 && (Ready === 1'b1 || Enable === 1'b1)) begin
      if (sbq.size() == 0) chk("unexpected_strobe", {Ready, Enable}, 0);
      else begin
        e = sbq.pop_front();
        chk("strobe_kind", Ready, e.rdy);
        chk("strobe_excl", Ready & Enable, 0);
        chk("strobe_cycle", cyc, e.cyc);
        if (e.rdy) begin
          chk("ready_init1", init1, e.i1);
          chk("ready_init2", init2, e.i2);
          chk("ready_scnt", sample_cnt, 0);
        end else chk("enable_scnt", sample_cnt, e.scnt);
      end
    end
  end

  task automatic tick();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic r, input int c, input logic [31:0] a, input logic [31:0] b, input logic [23:0] s);
    ev_t e;
    e.rdy = r; e.cyc = c; e.i1 = a; e.i2 = b; e.scnt = s;
    sbq.push_back(e);
  endtask

  task automatic cfg_write(input logic [31:0] i, input logic [31:0] c, input logic [15:0] d, input logic [23:0] r);
    cfg_init = i; cfg_coef = c; cfg_div = d; cfg_reload = r; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic stop_at(input int c);
    wait_until(c);
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, Ready, 0);
    chk({tag, "_enable"}, Enable, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_init1"}, init1, 0);
    chk({tag, "_init2"}, init2, 0);
    chk({tag, "_scnt"}, sample_cnt, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  initial begin
    int r0, t, s, st;
    vt[0] = '{32'h0C3EF153, 32'h3B20D79E, 16'd4, 24'd0, 3, 4};
    vt[1] = '{32'h11111111, 32'h22222222, 16'd0, 24'd0, 5, 1};
    vt[2] = '{32'h33333333, 32'h44444444, 16'd1, 24'd0, 5, 1};
    vt[3] = '{32'h55555555, 32'h66666666, 16'd2, 24'd3, 7, 2};
    vt[4] = '{32'h77777777, 32'h88888888, 16'd3, 24'd1, 4, 3};
    vt[5] = '{32'hDEADBEEF, 32'hCAFEF00D, 16'd7, 24'd2, 5, 7};

    tick(); tick();
    chk_all_zero("reset");
    #2 RESETn = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("nocfg_running", running, 0);
    chk("nocfg_ready", Ready, 0);

    foreach (vt[k]) begin
      cfg_write(vt[k].init, vt[k].coef, vt[k].div, vt[k].reload);
      chk("cfg_ready_low", cfg_ready, 0);
      start = 1'b1;
      r0 = cyc + 1;
      push(1'b1, r0, vt[k].init, vt[k].coef, 0);
      t = r0; s = 0;
      for (int n = 0; n < vt[k].nsamp; n++) begin
        t += vt[k].period;
        push(1'b0, t, 0, 0, 24'(s));
        s++;
        if (vt[k].reload != 0 && s == int'(vt[k].reload) && n < vt[k].nsamp - 1) begin
          t++;
          push(1'b1, t, vt[k].init, vt[k].coef, 0);
          s = 0;
        end
      end
      tick();
      start = 1'b0;
      chk("load_cfg_ready", cfg_ready, 1);
      chk("load_running", running, 1);
      stop_at(t);
      tick(); tick();
      chk("vec_stopped", running, 0);
      chk("vec_drain", sbq.size(), 0);
    end

    // new config while running: applied at the next sample, second write refused
    cfg_write(32'hAAAA0001, 32'hBBBB0001, 16'd4, 24'd0);
    start = 1'b1;
    r0 = cyc + 1;
    push(1'b1, r0, 32'hAAAA0001, 32'hBBBB0001, 0);
    push(1'b0, r0 + 4, 0, 0, 0);
    push(1'b0, r0 + 8, 0, 0, 1);
    push(1'b1, r0 + 9, 32'hAAAA0002, 32'hBBBB0002, 0);
    push(1'b0, r0 + 14, 0, 0, 0);
    push(1'b0, r0 + 19, 0, 0, 1);
    tick();
    start = 1'b0;
    wait_until(r0 + 5);
    cfg_write(32'hAAAA0002, 32'hBBBB0002, 16'd5, 24'd0);
    chk("pend_cfg_ready", cfg_ready, 0);
    cfg_write(32'hAAAA0003, 32'hBBBB0003, 16'd9, 24'd0);
    chk("pend_cfg_ready2", cfg_ready, 0);
    chk("pend_init1_hold", init1, 32'hAAAA0001);
    wait_until(r0 + 10);
    chk("reseed_cfg_ready", cfg_ready, 1);
    chk("reseed_init1", init1, 32'hAAAA0002);
    stop_at(r0 + 19);
    tick(); tick();
    chk("t5_drain", sbq.size(), 0);
    chk("t5_init1_kept", init1, 32'hAAAA0002);

    // stop on an Enable with a pending config, then resume and reset mid-run
    cfg_write(32'hD0D0D0D0, 32'hD1D1D1D1, 16'd3, 24'd0);
    start = 1'b1;
    r0 = cyc + 1;
    push(1'b1, r0, 32'hD0D0D0D0, 32'hD1D1D1D1, 0);
    push(1'b0, r0 + 3, 0, 0, 0);
    push(1'b0, r0 + 6, 0, 0, 1);
    tick();
    start = 1'b0;
    wait_until(r0 + 4);
    cfg_write(32'hE0E0E0E0, 32'hE1E1E1E1, 16'd2, 24'd0);
    stop_at(r0 + 6);
    tick(); tick(); tick();
    chk("t6_idle", running, 0);
    chk("t6_init1_hold", init1, 32'hD0D0D0D0);
    chk("t6_pending_kept", cfg_ready, 0);
    chk("t6_drain1", sbq.size(), 0);
    st = cyc;
    start = 1'b1;
    push(1'b1, st + 1, 32'hE0E0E0E0, 32'hE1E1E1E1, 0);
    push(1'b0, st + 3, 0, 0, 0);
    tick();
    start = 1'b0;
    wait_until(st + 4);
    chk("t6_running", running, 1);
    #2 RESETn = 1'b0;
    #1 chk_all_zero("async_reset");
    chk("t6_drain2", sbq.size(), 0);
    tick();
    RESETn = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
